issue_window_sequencer: RTL

//  Generates convolution window positions for a feature map of independent width/height, with

---
 rtl/issue_window_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/issue_window_sequencer.sv
// Convolution window position sequencer.
// Walks the centre of a (2R+1)x(2R+1) kernel over a padded feature map in
// row-major order, hands each position to the next allocator in turn, and
// after each group of positions offers the union bounding box of that group.
module issue_window_sequencer #(
   parameter int NUM_ALLOC = 220,
   parameter int COORD_W   = 8,
   parameter int PAD_W     = 2,
   parameter int STRIDE_W  = 3,
   parameter int ALLOC_W   = (NUM_ALLOC > 1) ? $clog2(NUM_ALLOC) : 1,
   parameter int CNT_W     = $clog2(NUM_ALLOC + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [COORD_W-1:0]   cfg_image_w,
   input  logic [COORD_W-1:0]   cfg_image_h,
   input  logic [PAD_W-1:0]     cfg_padding,
   input  logic [PAD_W-1:0]     cfg_radius,
   input  logic [STRIDE_W-1:0]  cfg_stride,
   input  logic                 start,
   output logic                 busy,
   output logic                 cfg_error,
   output logic                 issue_valid,
   input  logic                 issue_ready,
   output logic [COORD_W-1:0]   center_x,
   output logic [COORD_W-1:0]   center_y,
   output logic [COORD_W-1:0]   win_x_lo,
   output logic [COORD_W-1:0]   win_x_hi,
   output logic [COORD_W-1:0]   win_y_lo,
   output logic [COORD_W-1:0]   win_y_hi,
   output logic [ALLOC_W-1:0]   alloc_idx,
   output logic [NUM_ALLOC-1:0] alloc_select,
   output logic                 batch_valid,
   input  logic                 batch_ready,
   output logic [CNT_W-1:0]     batch_count,
   output logic [COORD_W-1:0]   batch_x_min,
   output logic [COORD_W-1:0]   batch_x_max,
   output logic [COORD_W-1:0]   batch_y_min,
   output logic [COORD_W-1:0]   batch_y_max,
   output logic                 done
);

   // Two spare bits so centre+stride and W+pad never wrap.
   localparam int XW = COORD_W + 2;

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_BATCH, S_FIN} state_t;

   state_t               state_q;
   logic [COORD_W-1:0]   w_q, h_q;
   logic [PAD_W-1:0]     pad_q, rad_q;
   logic [STRIDE_W-1:0]  stride_q;
   logic [COORD_W-1:0]   cx_q, cy_q;
   logic [COORD_W-1:0]   xlo_q, xhi_q, ylo_q, yhi_q;
   logic [ALLOC_W-1:0]   aidx_q;
   logic [CNT_W-1:0]     bcnt_q;
   logic [COORD_W-1:0]   bxmin_q, bxmax_q, bymin_q, bymax_q;
   logic                 last_q;
   logic                 err_q;

   logic [XW-1:0]        rad_x, pad_x, str_x, cx_max, cy_max, cx_step, cy_step;
   logic [COORD_W-1:0]   org, cx_d, cy_d;
   logic                 x_wrap, y_wrap, last_pos, cfg_bad;

   // Lower window edge, clamped at 0.
   function automatic logic [COORD_W-1:0] win_lo(input logic [COORD_W-1:0] c,
                                                 input logic [PAD_W-1:0]   r);
      logic [COORD_W-1:0] rw;
      rw = COORD_W'(r);
      return (c < rw) ? '0 : c - rw;
   endfunction

   // Upper window edge, clamped at dim-1.
   function automatic logic [COORD_W-1:0] win_hi(input logic [COORD_W-1:0] c,
                                                 input logic [PAD_W-1:0]   r,
                                                 input logic [COORD_W-1:0] dim);
      logic [XW-1:0] s, lim;
      s   = XW'(c) + XW'(r);
      lim = XW'(dim) - XW'(1);
      return COORD_W'((s > lim) ? lim : s);
   endfunction

   // Centre range, configuration legality and next-position arithmetic.
   always_comb begin
      rad_x    = XW'(rad_q);
      pad_x    = XW'(pad_q);
      str_x    = XW'(stride_q);
      cx_max   = XW'(w_q) - XW'(1) - rad_x + pad_x;
      cy_max   = XW'(h_q) - XW'(1) - rad_x + pad_x;
      cx_step  = XW'(cx_q) + str_x;
      cy_step  = XW'(cy_q) + str_x;
      x_wrap   = cx_step > cx_max;
      y_wrap   = cy_step > cy_max;
      last_pos = x_wrap && y_wrap;
      org      = COORD_W'(rad_q) - COORD_W'(pad_q);
      cx_d     = x_wrap ? org : COORD_W'(cx_step);
      cy_d     = x_wrap ? COORD_W'(cy_step) : cy_q;
      cfg_bad  = (stride_q == '0) || (pad_q > rad_q) ||
                 (XW'(w_q) + pad_x < rad_x + XW'(1)) ||
                 (XW'(h_q) + pad_x < rad_x + XW'(1));
   end

   // Sequencer FSM: config latch/check, position walk, batch accumulation and hand-off.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         w_q      <= '0;  h_q     <= '0;
         pad_q    <= '0;  rad_q   <= '0;  stride_q <= '0;
         cx_q     <= '0;  cy_q    <= '0;
         xlo_q    <= '0;  xhi_q   <= '0;  ylo_q    <= '0;  yhi_q   <= '0;
         aidx_q   <= '0;  bcnt_q  <= '0;
         bxmin_q  <= '0;  bxmax_q <= '0;  bymin_q  <= '0;  bymax_q <= '0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  w_q      <= cfg_image_w;
                  h_q      <= cfg_image_h;
                  pad_q    <= cfg_padding;
                  rad_q    <= cfg_radius;
                  stride_q <= cfg_stride;
                  err_q    <= 1'b0;
                  state_q  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (cfg_bad) begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  cx_q    <= org;
                  cy_q    <= org;
                  xlo_q   <= win_lo(org, rad_q);
                  xhi_q   <= win_hi(org, rad_q, w_q);
                  ylo_q   <= win_lo(org, rad_q);
                  yhi_q   <= win_hi(org, rad_q, h_q);
                  aidx_q  <= '0;
                  bcnt_q  <= '0;
                  last_q  <= 1'b0;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (issue_ready) begin
                  bcnt_q  <= bcnt_q + CNT_W'(1);
                  // First position of a batch seeds the box; later ones widen it.
                  bxmin_q <= (bcnt_q == '0 || xlo_q < bxmin_q) ? xlo_q : bxmin_q;
                  bxmax_q <= (bcnt_q == '0 || xhi_q > bxmax_q) ? xhi_q : bxmax_q;
                  bymin_q <= (bcnt_q == '0 || ylo_q < bymin_q) ? ylo_q : bymin_q;
                  bymax_q <= (bcnt_q == '0 || yhi_q > bymax_q) ? yhi_q : bymax_q;
                  if (!last_pos) begin
                     cx_q  <= cx_d;
                     cy_q  <= cy_d;
                     xlo_q <= win_lo(cx_d, rad_q);
                     xhi_q <= win_hi(cx_d, rad_q, w_q);
                     ylo_q <= win_lo(cy_d, rad_q);
                     yhi_q <= win_hi(cy_d, rad_q, h_q);
                  end
                  if (last_pos || aidx_q == ALLOC_W'(NUM_ALLOC - 1)) begin
                     last_q  <= last_pos;
                     state_q <= S_BATCH;
                  end else begin
                     aidx_q  <= aidx_q + ALLOC_W'(1);
                  end
               end
            end
            S_BATCH: begin
               if (batch_ready) begin
                  if (last_q) begin
                     state_q <= S_FIN;
                  end else begin
                     aidx_q  <= '0;
                     bcnt_q  <= '0;
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_FIN:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // One-hot allocator strobe, only while a position is on offer.
   always_comb begin
      alloc_select = '0;
      for (int i = 0; i < NUM_ALLOC; i++) begin
         if (issue_valid && (aidx_q == ALLOC_W'(i))) alloc_select[i] = 1'b1;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign issue_valid = (state_q == S_ISSUE);
   assign batch_valid = (state_q == S_BATCH);
   assign done        = (state_q == S_FIN);
   assign cfg_error   = err_q;
   assign center_x    = cx_q;
   assign center_y    = cy_q;
   assign win_x_lo    = xlo_q;
   assign win_x_hi    = xhi_q;
   assign win_y_lo    = ylo_q;
   assign win_y_hi    = yhi_q;
   assign alloc_idx   = aidx_q;
   assign batch_count = bcnt_q;
   assign batch_x_min = bxmin_q;
   assign batch_x_max = bxmax_q;
   assign batch_y_min = bymin_q;
   assign batch_y_max = bymax_q;

endmodule
